touch_button_conditioner: RTL and testbench

Front-end conditioner for the capacitive touch-button pad, directly upstream of the touch-driven LED logic. Synchronises the asynchronous pad level into `system_clock`, debounces it with a qualify-counter state machine, and delivers a clean pressed level, single-cycle press/release strobes and a press-toggled state. With the optional feature, it also strobes once on a long press.

---
 rtl/touch_button_conditioner.sv | 149 ++++++++++++++
 tb/tb_touch_button_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/touch_button_conditioner.sv
// Touch-pad front end: 2-flop synchroniser, qualify-counter debounce FSM, registered strobes.
// Optional long-press strobe enabled by defining TOUCH_LONG_PRESS_EN.
module touch_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES  = 50_000_000,
  parameter logic        TOUCH_ACTIVE_LEVEL = 1'b0
) (
  input  logic system_clock,
  input  logic system_reset,
  input  logic touch_button,
  output logic touch_level,
  output logic touch_press_pulse,
  output logic touch_release_pulse,
  output logic touch_toggle,
  output logic touch_long_pulse
);

`ifdef TOUCH_LONG_PRESS_EN
  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                   DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
`else
  localparam int unsigned CntMax = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
    $error("touch_button_conditioner: cycle parameters must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressQualify,
    StPressed,
    StReleaseQualify
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            active;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            toggle_q, toggle_d;

  assign active = (sync2_q == TOUCH_ACTIVE_LEVEL);

`ifdef TOUCH_LONG_PRESS_EN
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_PRESS_CYCLES - 1);
  logic long_q, long_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
`ifdef TOUCH_LONG_PRESS_EN
    long_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (active) begin
          state_d = StPressQualify;
          cnt_d   = '0;
        end
      end
      StPressQualify: begin
        if (!active) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d  = StPressed;
          cnt_d    = '0;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!active) begin
          state_d = StReleaseQualify;
          cnt_d   = '0;
        end else begin
`ifdef TOUCH_LONG_PRESS_EN
          // Saturation keeps cnt above LongLast, so one long strobe per press.
          if (cnt_q == LongLast) long_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StReleaseQualify: begin
        if (active) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    level_d = (state_d == StPressed) || (state_d == StReleaseQualify);
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      sync1_q   <= ~TOUCH_ACTIVE_LEVEL;
      sync2_q   <= ~TOUCH_ACTIVE_LEVEL;
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
`ifdef TOUCH_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= touch_button;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
`ifdef TOUCH_LONG_PRESS_EN
      long_q    <= long_d;
`endif
    end
  end

  assign touch_level         = level_q;
  assign touch_press_pulse   = press_q;
  assign touch_release_pulse = release_q;
  assign touch_toggle        = toggle_q;
`ifdef TOUCH_LONG_PRESS_EN
  assign touch_long_pulse    = long_q;
`else
  assign touch_long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_touch_button_conditioner.sv
// Directed bench for touch_button_conditioner (DEBOUNCE=4, LONG=16, active-low pad, 20 ns clock).
module tb_touch_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pad = 1'b1;
  logic level, press, release_p, toggle, long_p;

  int n_checks = 0;
  int n_fail   = 0;

  touch_button_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (16),
    .TOUCH_ACTIVE_LEVEL(1'b0)
  ) dut (
    .system_clock       (clk),
    .system_reset       (rst),
    .touch_button       (pad),
    .touch_level        (level),
    .touch_press_pulse  (press),
    .touch_release_pulse(release_p),
    .touch_toggle       (toggle),
    .touch_long_pulse   (long_p)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected strobe is seen; n = edges taken, -1 on timeout.
  task automatic wait_strobe(input bit want_press, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (want_press ? press : release_p) begin
        n = i;
        break;
      end
    end
  endtask

  int n, cnt_a, cnt_b, pos;

  initial begin
    // Reset held for two edges with the pad idle.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_level", level, 0);
    check_eq("rst_press", press, 0);
    check_eq("rst_release", release_p, 0);
    check_eq("rst_toggle", toggle, 0);
    check_eq("rst_long", long_p, 0);

    // Press: captured at edge E (first tick), strobe expected at E+6.
    pad = 1'b0;
    tick();
    cnt_a = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (press || level) cnt_a++;
    end
    check_eq("press_early", cnt_a, 0);
    tick();
    check_eq("press_strobe", press, 1);
    check_eq("press_level", level, 1);
    check_eq("press_toggle", toggle, 1);
    check_eq("press_release_low", release_p, 0);

    // Hold ~40 more cycles: strobe width, long-press behaviour.
    cnt_a = 0; cnt_b = 0; pos = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (long_p) begin
        cnt_b++;
        pos = i;
      end
      if (press || release_p || !level) cnt_a++;
    end
    check_eq("hold_quiet", cnt_a, 0);
`ifdef TOUCH_LONG_PRESS_EN
    check_eq("long_count", cnt_b, 1);
    check_eq("long_pos", pos, 16);
`else
    check_eq("long_count", cnt_b, 0);
`endif

    // Release latency and state.
    pad = 1'b1;
    wait_strobe(1'b0, n);
    check_eq("release_latency", n, 7);
    check_eq("release_level", level, 0);
    check_eq("release_toggle", toggle, 1);
    check_eq("release_press_low", press, 0);
    tick();
    check_eq("release_width", release_p, 0);

    // Three-cycle active glitch must not qualify.
    pad = 1'b0;
    tick(); tick(); tick();
    pad = 1'b1;
    cnt_a = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (press || release_p || level) cnt_a++;
    end
    check_eq("short_press_ignored", cnt_a, 0);
    check_eq("short_press_toggle", toggle, 1);

    // Second press, then a two-cycle inactive glitch while pressed.
    pad = 1'b0;
    wait_strobe(1'b1, n);
    check_eq("press2_latency", n, 7);
    check_eq("press2_toggle", toggle, 0);
    tick(); tick(); tick();
    pad = 1'b1;
    tick(); tick();
    pad = 1'b0;
    cnt_a = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (press || release_p || !level) cnt_a++;
    end
    check_eq("glitch_ignored", cnt_a, 0);
    check_eq("glitch_toggle", toggle, 0);

    // Release, then press and reset two cycles after the strobe.
    pad = 1'b1;
    wait_strobe(1'b0, n);
    check_eq("release2_latency", n, 7);
    tick();
    pad = 1'b0;
    wait_strobe(1'b1, n);
    check_eq("press3_latency", n, 7);
    check_eq("press3_toggle", toggle, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_toggle", toggle, 0);
    check_eq("mid_rst_release", release_p, 0);
    check_eq("mid_rst_press", press, 0);
    cnt_a = 0; pos = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (release_p) cnt_a++;
      if (press && pos < 0) pos = i;
    end
    check_eq("post_rst_no_release", cnt_a, 0);
    check_eq("post_rst_press_pos", pos, 7);
    check_eq("post_rst_toggle", toggle, 1);
    check_eq("post_rst_level", level, 1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
